sys_cmd_decoder: RTL and testbench
==================================

// Module: sys_cmd_decoder
// PURPOSE
//  Responder end of the UART command protocol. Sits in the REF_CLK domain between the RX
//  data synchronizer and the register file, ALU, clock gate and TX FIFO. Parses the
//  received byte stream into write, read, ALU-with-operands and ALU-no-operands commands.
//  Drives the register file and ALU strobes and pushes response bytes toward the TX FIFO.
// PARAMETERS
//  DATA_WIDTH      8    byte width of RX/TX data and of register file data
//  ADDRESS_WIDTH   4    register file address width; the low bits of the address byte are used
//  ALU_FUN_WIDTH   4    ALU function code width; the low bits of the function byte are used
//  ALU_OUT_WIDTH   16   ALU result width; transmitted as 2 bytes, LSB first
//  TIMEOUT_CYCLES  4096 inter-byte timeout in CLK cycles (used only with CMD_TIMEOUT_EN)
// PORTS
//  CLK          in   1              REF_CLK-domain clock
//  RST          in   1              asynchronous active-low reset
//  RX_P_DATA    in   DATA_WIDTH     received byte, valid with RX_D_VLD
//  RX_D_VLD     in   1              1-cycle pulse per received byte (already synchronized)
//  RF_RdData    in   DATA_WIDTH     register file read data
//  RF_RdData_VLD in  1              register file read data valid
//  ALU_OUT      in   ALU_OUT_WIDTH  ALU result
//  ALU_OUT_VLD  in   1              ALU result valid
//  TX_FULL      in   1              TX FIFO full; no push is allowed while high
//  RF_WrEn      out  1              register file write strobe, 1 cycle
//  RF_RdEn      out  1              register file read strobe, 1 cycle
//  RF_Address   out  ADDRESS_WIDTH  register file address
//  RF_WrData    out  DATA_WIDTH     register file write data
//  ALU_EN       out  1              ALU start strobe, 1 cycle
//  ALU_FUN      out  ALU_FUN_WIDTH  ALU function code
//  CLK_GATE_EN  out  1              ALU clock gate enable
//  TX_P_DATA    out  DATA_WIDTH     response byte
//  TX_D_VLD     out  1              TX FIFO push, 1 cycle
//  CMD_ERR      out  1              1-cycle pulse on an unknown opcode, a dropped byte or a timeout
// BEHAVIOUR
//  - All outputs are registered. Every output resets to 0 and the FSM resets to IDLE.
//    Reset mid-frame discards the partial command. No strobe fires after RST deasserts
//    until a new frame arrives.
//  - Opcodes: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands.
//  - State transitions (each byte-consuming step advances on RX_D_VLD):
//    IDLE:     0xAA->WR_ADDR; 0xBB->RD_ADDR; 0xCC->ALU_OPA; 0xDD->ALU_FN.
//              Any other byte: CMD_ERR pulse, stay in IDLE.
//    WR_ADDR:  latch the address -> WR_DATA.
//    WR_DATA:  RF_WrEn=1 with RF_Address/RF_WrData for 1 cycle -> IDLE.
//    RD_ADDR:  RF_RdEn=1 for 1 cycle -> RD_WAIT.
//    RD_WAIT:  on RF_RdData_VLD latch the data -> TX_RD.
//    TX_RD:    when TX_FULL=0, TX_D_VLD=1 for 1 cycle -> IDLE.
//    ALU_OPA:  write the byte to RF address 0 -> ALU_OPB.
//    ALU_OPB:  write the byte to RF address 1 -> ALU_FN.
//    ALU_FN:   latch ALU_FUN, ALU_EN=1 for 1 cycle -> ALU_WAIT.
//    ALU_WAIT: on ALU_OUT_VLD latch the result -> TX_LSB.
//    TX_LSB:   push ALU_OUT[7:0] when TX_FULL=0 -> TX_MSB.
//    TX_MSB:   push ALU_OUT[15:8] when TX_FULL=0 -> IDLE.
//  - Latency: each strobe (RF_WrEn, RF_RdEn, ALU_EN) asserts in the cycle after the
//    RX_D_VLD of the final byte. Each TX push occurs 1 cycle after its data is latched,
//    or on the first cycle that TX_FULL=0.
//  - CLK_GATE_EN is 1 while in ALU_OPA..ALU_WAIT. It is already 1 the cycle before ALU_EN
//    asserts and drops to 0 the cycle after ALU_OUT_VLD.
//  - An RX_D_VLD that arrives in RD_WAIT, ALU_WAIT or any TX_* state drops the byte and
//    pulses CMD_ERR. The FSM does not change state.
//  - RX_D_VLD and RF_RdData_VLD or ALU_OUT_VLD in the same cycle: the VLD is served and
//    the RX byte is dropped with CMD_ERR.
//  - TX_FULL held high stalls the FSM in its TX state indefinitely. TX_P_DATA stays stable.
// CONFIGURATION
//  - CMD_TIMEOUT_EN defined: a counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB
//    and ALU_FN. The counter clears on every RX_D_VLD and on every state change.
//    Reaching TIMEOUT_CYCLES-1 forces IDLE and pulses CMD_ERR. No RF write occurs for
//    the aborted frame.
//  - CMD_TIMEOUT_EN undefined: there is no counter and the byte-waiting states wait
//    forever.
// STRUCTURE
//  - sys_cmd_pkg holds the opcode constants (CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC,
//    CMD_ALU_NOP=0xDD), the state encoding localparams and ALU operand addresses 0 and 1.
//  - Sub-module cmd_timeout_timer (count, clear, expire pulse) is instantiated only under
//    CMD_TIMEOUT_EN.
// TESTING
//  1. Write frame: RX AA,05,77 -> exactly one RF_WrEn pulse with addr 5, data 0x77.
//     No TX_D_VLD.
//  2. Read frame: RX BB,02; then RF_RdData=0x3C with VLD -> one RF_RdEn at addr 2,
//     then one TX push of 0x3C.
//  3. ALU with operands: RX CC,05,03,01 -> RF writes addr0=05 and addr1=03, then ALU_FUN=1
//     with ALU_EN asserted while CLK_GATE_EN=1. ALU_OUT=0x0102 -> TX pushes 02 then 01.
//  4. Backpressure: RX DD,02 with TX_FULL=1 held for 10 cycles after ALU_OUT_VLD -> no
//     TX_D_VLD until release, then 2 pushes with correct data.
//  5. Errors: RX 0x55 -> CMD_ERR pulse, state stays IDLE. A byte during RD_WAIT ->
//     CMD_ERR, and the read completes normally.
//  6. Reset/timeout: RST low after AA,05 -> no write after the next single byte. With the
//     macro, AA then silence for TIMEOUT_CYCLES -> CMD_ERR, then a fresh AA frame
//     succeeds.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg
//   Shared definitions for the UART command decoder: opcode bytes, FSM state
//   encoding, the register file addresses that receive the ALU operands, and a
//   helper that identifies the states that wait for the next command byte.
//   No ports; imported by sys_cmd_decoder.
package sys_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_TX_RD    = 4'd5;
    localparam logic [3:0] ST_ALU_OPA  = 4'd6;
    localparam logic [3:0] ST_ALU_OPB  = 4'd7;
    localparam logic [3:0] ST_ALU_FN   = 4'd8;
    localparam logic [3:0] ST_ALU_WAIT = 4'd9;
    localparam logic [3:0] ST_TX_LSB   = 4'd10;
    localparam logic [3:0] ST_TX_MSB   = 4'd11;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_WR_ADDR  = ST_WR_ADDR,
        S_WR_DATA  = ST_WR_DATA,
        S_RD_ADDR  = ST_RD_ADDR,
        S_RD_WAIT  = ST_RD_WAIT,
        S_TX_RD    = ST_TX_RD,
        S_ALU_OPA  = ST_ALU_OPA,
        S_ALU_OPB  = ST_ALU_OPB,
        S_ALU_FN   = ST_ALU_FN,
        S_ALU_WAIT = ST_ALU_WAIT,
        S_TX_LSB   = ST_TX_LSB,
        S_TX_MSB   = ST_TX_MSB
    } state_t;

    localparam int ALU_OPA_ADDR = 0;
    localparam int ALU_OPB_ADDR = 1;

    // States that sit waiting for the next byte of a frame.
    function automatic logic waits_for_byte(input state_t s);
        return (s == S_WR_ADDR) || (s == S_WR_DATA) || (s == S_RD_ADDR) ||
               (s == S_ALU_OPA) || (s == S_ALU_OPB) || (s == S_ALU_FN);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// cmd_timeout_timer
//   Inter-byte timeout. Down-counter reloaded with TIMEOUT_CYCLES-1 on clear
//   or while not running; expire is high once the count reaches zero while run
//   is high.
// Ports
//   CLK     in  clock
//   RST     in  asynchronous active-low reset
//   run     in  count while high
//   clear   in  reload the counter
//   expire  out terminal count reached
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of clear so the decoder can derive clear from its next state.
    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder
//   Responder end of the UART command protocol. Parses write (AA), read (BB),
//   ALU-with-operands (CC) and ALU-without-operands (DD) frames, strobes the
//   register file and ALU, and pushes response bytes toward the TX FIFO.
//   Optional inter-byte timeout: define CMD_TIMEOUT_EN.
// Ports
//   CLK, RST (async active-low)
//   RX_P_DATA/RX_D_VLD          received byte stream
//   RF_RdData/RF_RdData_VLD     register file read return
//   ALU_OUT/ALU_OUT_VLD         ALU result return
//   TX_FULL                     TX FIFO full
//   RF_WrEn/RF_RdEn/RF_Address/RF_WrData   register file access
//   ALU_EN/ALU_FUN/CLK_GATE_EN  ALU control
//   TX_P_DATA/TX_D_VLD          TX FIFO push
//   CMD_ERR                     unknown opcode, dropped byte or timeout
//
// state    | meaning
// IDLE     | waiting for an opcode
// WR_ADDR  | write: waiting for address
// WR_DATA  | write: waiting for data
// RD_ADDR  | read: waiting for address
// RD_WAIT  | read: waiting for RF_RdData_VLD
// TX_RD    | read: pushing read data
// ALU_OPA  | ALU: waiting for operand A (to RF addr 0)
// ALU_OPB  | ALU: waiting for operand B (to RF addr 1)
// ALU_FN   | ALU: waiting for function byte
// ALU_WAIT | ALU: waiting for ALU_OUT_VLD
// TX_LSB   | ALU: pushing result low byte
// TX_MSB   | ALU: pushing result high byte
module sys_cmd_decoder
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int ALU_OUT_WIDTH = 16
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_VLD,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    input  logic                     TX_FULL,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDRESS_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    output logic                     ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);

    state_t                   state_q, state_d;
    logic                     rf_wren_q, rf_wren_d;
    logic                     rf_rden_q, rf_rden_d;
    logic [ADDRESS_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]    rf_wrdata_q, rf_wrdata_d;
    logic                     alu_en_q, alu_en_d;
    logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
    logic                     clk_gate_q, clk_gate_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic                     tx_vld_q, tx_vld_d;
    logic                     cmd_err_q, cmd_err_d;
    logic [ALU_OUT_WIDTH-1:0] alu_res_q, alu_res_d;
    logic                     tmo_expire;

`ifdef CMD_TIMEOUT_EN
    logic tmo_run, tmo_clear;

    assign tmo_run   = waits_for_byte(state_q);
    assign tmo_clear = RX_D_VLD || (state_d != state_q);

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .run    (tmo_run),
        .clear  (tmo_clear),
        .expire (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rf_wren_d   = 1'b0;
        rf_rden_d   = 1'b0;
        alu_en_d    = 1'b0;
        tx_vld_d    = 1'b0;
        cmd_err_d   = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_wrdata_d = rf_wrdata_q;
        alu_fun_d   = alu_fun_q;
        tx_data_d   = tx_data_q;
        alu_res_d   = alu_res_q;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_d = S_WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = S_RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = S_ALU_OPA;
                    else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = S_ALU_FN;
                    else                                            cmd_err_d = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wrdata_d = RX_P_DATA;
                    rf_wren_d   = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    rf_rden_d = 1'b1;
                    state_d   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (RF_RdData_VLD) begin
                    tx_data_d = RF_RdData;
                    state_d   = S_TX_RD;
                end
            end
            S_TX_RD: begin
                cmd_err_d = RX_D_VLD;
                if (!TX_FULL) begin
                    tx_vld_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ALU_OPA: begin
                if (RX_D_VLD) begin
                    rf_addr_d   = ADDRESS_WIDTH'(ALU_OPA_ADDR);
                    rf_wrdata_d = RX_P_DATA;
                    rf_wren_d   = 1'b1;
                    state_d     = S_ALU_OPB;
                end
            end
            S_ALU_OPB: begin
                if (RX_D_VLD) begin
                    rf_addr_d   = ADDRESS_WIDTH'(ALU_OPB_ADDR);
                    rf_wrdata_d = RX_P_DATA;
                    rf_wren_d   = 1'b1;
                    state_d     = S_ALU_FN;
                end
            end
            S_ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                cmd_err_d = RX_D_VLD;
                if (ALU_OUT_VLD) begin
                    alu_res_d = ALU_OUT;
                    state_d   = S_TX_LSB;
                end
            end
            S_TX_LSB: begin
                cmd_err_d = RX_D_VLD;
                if (!TX_FULL) begin
                    tx_data_d = alu_res_q[DATA_WIDTH-1:0];
                    tx_vld_d  = 1'b1;
                    state_d   = S_TX_MSB;
                end
            end
            S_TX_MSB: begin
                cmd_err_d = RX_D_VLD;
                if (!TX_FULL) begin
                    tx_data_d = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_vld_d  = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving on the expiry cycle still counts, so the timeout
        // only wins when the line is quiet.
        if (tmo_expire && !RX_D_VLD) begin
            state_d   = S_IDLE;
            cmd_err_d = 1'b1;
        end

        clk_gate_d = (state_d == S_ALU_OPA) || (state_d == S_ALU_OPB) ||
                     (state_d == S_ALU_FN)  || (state_d == S_ALU_WAIT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            rf_wren_q   <= 1'b0;
            rf_rden_q   <= 1'b0;
            rf_addr_q   <= '0;
            rf_wrdata_q <= '0;
            alu_en_q    <= 1'b0;
            alu_fun_q   <= '0;
            clk_gate_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            alu_res_q   <= '0;
        end else begin
            state_q     <= state_d;
            rf_wren_q   <= rf_wren_d;
            rf_rden_q   <= rf_rden_d;
            rf_addr_q   <= rf_addr_d;
            rf_wrdata_q <= rf_wrdata_d;
            alu_en_q    <= alu_en_d;
            alu_fun_q   <= alu_fun_d;
            clk_gate_q  <= clk_gate_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            cmd_err_q   <= cmd_err_d;
            alu_res_q   <= alu_res_d;
        end
    end

    assign RF_WrEn     = rf_wren_q;
    assign RF_RdEn     = rf_rden_q;
    assign RF_Address  = rf_addr_q;
    assign RF_WrData   = rf_wrdata_q;
    assign ALU_EN      = alu_en_q;
    assign ALU_FUN     = alu_fun_q;
    assign CLK_GATE_EN = clk_gate_q;
    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
module tb_sys_cmd_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_FULL;
    logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, CMD_ERR;
    logic [3:0]  RF_Address, ALU_FUN;
    logic [7:0]  RF_WrData, TX_P_DATA;

    localparam int TMO = 4096;

    sys_cmd_decoder dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .TX_FULL       (TX_FULL),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .RF_Address    (RF_Address),
        .RF_WrData     (RF_WrData),
        .ALU_EN        (ALU_EN),
        .ALU_FUN       (ALU_FUN),
        .CLK_GATE_EN   (CLK_GATE_EN),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .CMD_ERR       (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int exp_err = 0;
    int obs_err = 0;

    logic [11:0] exp_wr[$];   // {addr, data}
    logic [3:0]  exp_rd[$];
    logic [3:0]  exp_alu[$];
    logic [7:0]  exp_tx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every DUT strobe pops one expected entry.
    always @(negedge CLK) begin
        if (RF_WrEn) begin
            chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) chk("wr_addr_data", {20'd0, RF_Address, RF_WrData}, {20'd0, exp_wr.pop_front()});
        end
        if (RF_RdEn) begin
            chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
            if (exp_rd.size() != 0) chk("rd_addr", {28'd0, RF_Address}, {28'd0, exp_rd.pop_front()});
        end
        if (ALU_EN) begin
            chk("alu_expected", 32'(exp_alu.size() != 0), 32'd1);
            if (exp_alu.size() != 0) chk("alu_fun", {28'd0, ALU_FUN}, {28'd0, exp_alu.pop_front()});
            chk("alu_en_gate", {31'd0, CLK_GATE_EN}, 32'd1);
        end
        if (TX_D_VLD) begin
            chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) chk("tx_data", {24'd0, TX_P_DATA}, {24'd0, exp_tx.pop_front()});
        end
        if (CMD_ERR) obs_err++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        cycles(2);
    endtask

    task automatic rd_return(input logic [7:0] d);
        @(posedge CLK); #1;
        RF_RdData     = d;
        RF_RdData_VLD = 1'b1;
        @(posedge CLK); #1;
        RF_RdData_VLD = 1'b0;
    endtask

    // Optionally collides an RX byte with the ALU result to check it is dropped.
    task automatic alu_return(input logic [15:0] r, input logic collide);
        @(negedge CLK);
        chk("gate_before_vld", {31'd0, CLK_GATE_EN}, 32'd1);
        @(posedge CLK); #1;
        ALU_OUT     = r;
        ALU_OUT_VLD = 1'b1;
        if (collide) begin
            RX_P_DATA = 8'h99;
            RX_D_VLD  = 1'b1;
        end
        @(posedge CLK); #1;
        ALU_OUT_VLD = 1'b0;
        RX_D_VLD    = 1'b0;
        @(negedge CLK);
        chk("gate_after_vld", {31'd0, CLK_GATE_EN}, 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
                exp_alu.size() != 0) && n < 50) begin
            cycles(1);
            n++;
        end
        cycles(3);
        chk({tag, "_pending"}, exp_tx.size() + exp_wr.size() + exp_rd.size() + exp_alu.size(), 0);
        chk({tag, "_err_cnt"}, obs_err, exp_err);
    endtask

    initial begin
        RST = 1'b0;
        RX_P_DATA = '0; RX_D_VLD = 1'b0;
        RF_RdData = '0; RF_RdData_VLD = 1'b0;
        ALU_OUT = '0;   ALU_OUT_VLD = 1'b0;
        TX_FULL = 1'b0;
        cycles(3);
        @(negedge CLK);
        chk("rst_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                            CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 32'd0);
        RST = 1'b1;
        cycles(3);

        // Write frame
        exp_wr.push_back({4'h5, 8'h77});
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h77);
        drain("write");

        // Read frame
        exp_rd.push_back(4'h2);
        exp_tx.push_back(8'h3C);
        send_byte(8'hBB); send_byte(8'h02);
        rd_return(8'h3C);
        drain("read");

        // ALU with operands; RX byte collides with ALU_OUT_VLD
        exp_wr.push_back({4'h0, 8'h05});
        exp_wr.push_back({4'h1, 8'h03});
        exp_alu.push_back(4'h1);
        exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h01);
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h01);
        exp_err++;
        alu_return(16'h0102, 1'b1);
        drain("alu_op");

        // ALU without operands under backpressure
        TX_FULL = 1'b1;
        exp_alu.push_back(4'h2);
        send_byte(8'hDD); send_byte(8'h02);
        alu_return(16'hBEEF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("stall_no_push", {31'd0, TX_D_VLD}, 32'd0);
        end
        exp_tx.push_back(8'hEF);
        exp_tx.push_back(8'hBE);
        @(posedge CLK); #1;
        TX_FULL = 1'b0;
        drain("alu_nop");

        // Unknown opcode stays in IDLE; following write still decodes
        exp_err++;
        send_byte(8'h55);
        exp_wr.push_back({4'hA, 8'h5A});
        send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h5A);
        drain("bad_opcode");

        // Byte during RD_WAIT is dropped, read completes
        exp_rd.push_back(4'h7);
        exp_tx.push_back(8'hC3);
        send_byte(8'hBB); send_byte(8'h07);
        exp_err++;
        send_byte(8'h99);
        rd_return(8'hC3);
        drain("rd_wait_byte");

        // Reset mid-frame: following byte is treated as an opcode, no write
        send_byte(8'hAA); send_byte(8'h05);
        @(posedge CLK); #1;
        RST = 1'b0;
        cycles(2);
        RST = 1'b1;
        cycles(2);
        exp_err++;
        send_byte(8'h11);
        drain("reset_mid");

`ifdef CMD_TIMEOUT_EN
        // Silence after opcode times out; a fresh frame then succeeds
        send_byte(8'hAA);
        exp_err++;
        cycles(TMO + 10);
        chk("timeout_err", obs_err, exp_err);
        exp_wr.push_back({4'h3, 8'h44});
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h44);
        drain("timeout");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
